// File: rtl/fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : fifo_pkg                                                |
// | Purpose  : Shared defaults and occupancy-update helper for fifo    |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH_DEFAULT = 8;
  localparam int FIFO_ADDR_WIDTH_DEFAULT = 4;

  // How the occupancy counter moves on a given edge
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_step_e;

  // A lone write grows the queue, a lone read shrinks it, anything else holds
  function automatic cnt_step_e count_step(input logic wr_ok, input logic rd_ok);
    if (wr_ok && !rd_ok) return CNT_INC;
    if (rd_ok && !wr_ok) return CNT_DEC;
    return CNT_HOLD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : fifo_ram                                                |
// | Purpose  : Simple dual-port RAM, sync write, registered sync read  |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int c_depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_depth];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Write port: array is deliberately not reset so it maps onto block RAM
  always_ff @(posedge clock) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Read port: read-before-write when addresses collide (full with rd & wr);
  // only the output register is cleared so dout reads 0 after reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)  r_rdata <= '0;
    else if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : fifo                                                    |
// | Purpose  : Single-clock byte FIFO with status flags and error      |
// |            pulses for rejected accesses                            |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0]   c_depth_count = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   c_count_one   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] c_ptr_one     = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic [ADDR_WIDTH:0]   w_count_next;

  // A read needs data; a write needs room, or a slot freed by a same-edge read.
  // An empty FIFO never forwards the incoming word to the reader.
  assign w_rd_ok = rd && !r_empty;
  assign w_wr_ok = wr && (!r_full || w_rd_ok);

  // Next occupancy, from which full/empty are also registered
  always_comb begin
    w_count_next = r_count;
    case (count_step(w_wr_ok, w_rd_ok))
      CNT_INC: w_count_next = r_count + c_count_one;
      CNT_DEC: w_count_next = r_count - c_count_one;
      default: w_count_next = r_count;
    endcase
  end

  // Pointers, occupancy, flags and one-cycle error pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + c_ptr_one;
      if (w_rd_ok) r_rptr <= r_rptr + c_ptr_one;
      r_count     <= w_count_next;
      r_full      <= (w_count_next == c_depth_count);
      r_empty     <= (w_count_next == '0);
      r_overflow  <= wr && !w_wr_ok;
      r_underflow <= rd && r_empty;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (w_wr_ok),
    .waddr (r_wptr),
    .wdata (din),
    .re    (w_rd_ok),
    .raddr (r_rptr),
    .rdata (dout)
  );

  assign full      = r_full;
  assign empty     = r_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_fifo                                                 |
// | Purpose  : Self-checking bench for fifo against a queue model      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          wr    = 1'b0;
  logic          rd    = 1'b0;
  logic [DW-1:0] din   = '0;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int n_err    = 0;
  int n_checks = 0;

  // Reference model: contents as a queue plus the observable registers
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_of   = 1'b0;
  logic          m_uf   = 1'b0;

  fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .wr        (wr),
    .rd        (rd),
    .din       (din),
    .dout      (dout),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".dout"},      32'(dout),      32'(m_dout));
    chk({tag, ".count"},     32'(count),     32'(q.size()));
    chk({tag, ".full"},      32'(full),      32'(q.size() == DEPTH));
    chk({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_of));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_uf));
  endtask

  // One clock edge of access; model follows the accept/reject rules directly
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
    bit rd_ok, wr_ok;
    wr = w; rd = r; din = d;
    @(posedge clock);
    #1;
    rd_ok = r && (q.size() > 0);
    wr_ok = w && ((q.size() < DEPTH) || rd_ok);
    m_uf  = r && (q.size() == 0);
    m_of  = w && !wr_ok;
    if (rd_ok) m_dout = q.pop_front();
    if (wr_ok) q.push_back(d);
    chk_all(tag);
    wr = 1'b0; rd = 1'b0;
  endtask

  initial begin
    string s;

    // Power-on reset, with a write pending that must be discarded
    wr = 1'b1; din = 8'h55;
    repeat (2) @(posedge clock);
    #1;
    wr = 1'b0;
    chk_all("por");
    reset = 1'b1;

    // Asynchronous reset in the middle of operation with 5 words stored
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'($urandom), "pre_rst_wr");
    step(1'b1, 1'b1, 8'h77, "pre_rst_rw");
    #2;
    wr = 1'b1; rd = 1'b1;
    reset = 1'b0;
    #1;
    q.delete(); m_dout = '0; m_of = 1'b0; m_uf = 1'b0;
    chk_all("async_rst");
    @(posedge clock);
    #1;
    chk_all("rst_hold");
    wr = 1'b0; rd = 1'b0;
    reset = 1'b1;
    step(1'b0, 1'b1, 8'h00, "rd_after_rst");
    chk("rd_after_rst.uf_const", 32'(underflow), 32'd1);
    chk("rd_after_rst.dout_const", 32'(dout), 32'd0);

    // Fill, then five overflowing writes
    s = "Hola mundo.12345";
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'(s[i]), "fill");
    chk("fill.count_const", 32'(count), 32'd16);
    chk("fill.full_const", 32'(full), 32'd1);
    s = "67890";
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(s[i]), "ovf");
    chk("ovf.count_const", 32'(count), 32'd16);

    // Drain order
    s = "Hol";
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h00, "drain");
      chk("drain.char", 32'(dout), 32'(s[i]));
    end
    chk("drain.count_const", 32'(count), 32'd13);

    // Wrap-around
    s = "abc";
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(s[i]), "wrap_wr");
    s = "a mundo.12345abc";
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00, "wrap_rd");
      chk("wrap_rd.char", 32'(dout), 32'(s[i]));
    end
    chk("wrap.empty_const", 32'(empty), 32'd1);

    // Simultaneous access with 4 stored, then at empty
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(8'h10 + i), "sim_fill");
    step(1'b1, 1'b1, 8'h99, "sim_mid");
    chk("sim_mid.dout_const", 32'(dout), 32'h10);
    chk("sim_mid.count_const", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, "sim_drain");
    step(1'b1, 1'b1, 8'h5a, "sim_empty");
    chk("sim_empty.count_const", 32'(count), 32'd1);
    chk("sim_empty.dout_const", 32'(dout), 32'h99);

    // Simultaneous access at full
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, DW'($urandom), "sim_full_fill");
    step(1'b1, 1'b1, 8'hc3, "sim_full");
    chk("sim_full.count_const", 32'(count), 32'd16);

    // Held write strobe: three edges, three accepted writes
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, "held_drain");
    wr = 1'b1; din = 8'h41;
    repeat (3) @(posedge clock);
    #1;
    wr = 1'b0;
    for (int i = 0; i < 3; i++) q.push_back(8'h41);
    m_of = 1'b0; m_uf = 1'b0;
    chk_all("held");
    chk("held.count_const", 32'(count), 32'd3);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom), "rand");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo.md
# fifo

Synchronous single-clock first-in/first-out buffer that decouples a byte producer (e.g. audio sample capture) from a consumer running on the same clock. Writes and reads are level-sampled strobes on the rising clock edge; status flags report full/empty/occupancy, and one-cycle error pulses flag rejected accesses. Storage is a small inferred dual-port memory.

## Interface
- DATA_WIDTH, 8, width of each stored word
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH = 16 words

- clock  in  1  single system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- wr  in  1  write strobe, sampled each rising edge
- rd  in  1  read strobe, sampled each rising edge
- din  in  DATA_WIDTH  write data, captured when a write is accepted
- dout  out  DATA_WIDTH  registered read data
- full  out  1  occupancy == DEPTH
- empty  out  1  occupancy == 0
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected because full
- underflow  out  1  one-cycle pulse: read rejected because empty

## Operation
- Write accepted when wr=1 and (not full, or rd=1 is also accepted this edge): mem[wptr] <= din, wptr increments.
- Read accepted when rd=1 and not empty: dout <= mem[rptr], rptr increments.
- Strobes are levels: every rising edge with wr (rd) high is a separate access; a strobe held across N edges performs N accesses.
- Pointers are ADDR_WIDTH bits and wrap DEPTH-1 -> 0 naturally.
- count: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither accepted.
- full/empty/count are registered, consistent with pointers after each edge.
- dout holds last read value until the next accepted read; unaffected by writes and rejected reads.
- Rejected write (wr=1, full, rd=0): no state change except overflow=1 for that cycle; din discarded.
- Rejected read (rd=1, empty): dout and pointers unchanged, underflow=1 for that cycle.
- Simultaneous rd & wr when empty: write accepted, read rejected (no fall-through), underflow pulses, count -> 1.
- Simultaneous rd & wr when full: both accepted, count stays DEPTH, full stays 1.
- Simultaneous rd & wr otherwise: both accepted, count unchanged.

## Timing
- Reset (reset=0, asynchronous, any time): wptr=0, rptr=0, count=0, empty=1, full=0, dout=0, overflow=0, underflow=0. Memory contents not cleared. In-flight accesses on the edge coinciding with reset are discarded.
- Release of reset synchronous in effect: first access possible on the first rising edge with reset=1.
- Write-to-read latency: word written at edge k is readable at edge k+1 (empty deasserts after edge k).
- Read latency: dout valid after the edge at which the read is accepted (1 cycle from strobe sample).
- overflow/underflow are high exactly for the cycle following the rejecting edge.

## Structure
- No shared package required; DATA_WIDTH/ADDR_WIDTH are module parameters.
- One sub-module natural: fifo_ram — simple dual-port RAM, DEPTH x DATA_WIDTH, synchronous write port (we, waddr, wdata), synchronous read port (re, raddr, rdata). No reset on the array.
- Top level holds pointers, count, flags, error pulses.

## Test plan
- Reset: drive reset=0 mid-operation with 5 words stored -> all outputs reach reset values immediately; after release empty=1, count=0, a read gives underflow=1 and dout=0.
- Fill: write "Hola mundo.12345" (16 bytes) -> count=16, full=1 after 16th edge; 17th–21st writes ("67890") each pulse overflow, count stays 16.
- Drain order: 3 reads after fill -> dout = 'H','o','l' in order, count=13, full=0.
- Wrap-around: then write 'a','b','c' (pointers wrap), read 16 times -> dout sequence "a mundo.12345abc" beginning 'a', last three 'a','b','c'; final empty=1.
- Simultaneous: with 4 words stored, rd=wr=1 for one edge -> count stays 4, oldest word on dout; at empty, rd=wr=1 -> count=1, underflow=1, dout unchanged.
- Held strobe: wr held high 3 edges with din=0x41 -> count +3.
